kgp_control_unit: RTL
=====================

# kgp_control_unit

Multicycle control FSM for the KGP-RISC processor. It sits directly upstream of the datapath: it consumes the instruction register contents (`irout`) and drives every load-enable, mux-select, ALU and memory control line the datapath needs for each IF/ID/EX/MEM/WB step. It also provides the register-file write enable (`regwrite`) and halt/illegal status.

## Interface
Parameters:
- None. Encodings live in `kgp_ctrl_pkg`.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `irout` input 32: instruction register output. Fields:
  - opcode = `[31:26]`
  - funct = `[3:0]`
- `dmem_ready` input 1: data memory ready. Present only with `KGP_MEM_WAIT_EN`.
- `readim`, `ldir`, `ldnpc` output 1 each: fetch controls.
- `ldA`, `ldB`, `ldimm` output 1 each: decode latches.
- `opcond` output 2: branch condition.
  - 00 always, 01 A==0, 10 A!=0, 11 A<0.
- `alusel1` output 1: ALU input 1 select; 1 = A, 0 = NPC.
- `alusel2` output 1: ALU input 2 select; 1 = imm, 0 = B.
- `aluen`, `ldaluout` output 1 each.
- `alufunc` output 4: ALU operation.
- `writedmem`, `readdmem`, `ldlmd` output 1 each.
- `selwb` output 1: write-back select; 1 = ALU result, 0 = LMD.
- `regwrite`, `branch`, `ldpc` output 1 each.
- `retire` output 1: one-cycle pulse, coincident with `ldpc`.
- `halted` output 1: FSM is in HALT.
- `illegal` output 1: sticky; set when HALT was entered via an illegal opcode.

## Operation
Instruction classes, decoded from the opcode:
- R-ALU, 6'h00: `alufunc` = funct.
- I-ALU, 6'b01xxxx: `alufunc` = opcode[3:0].
- LD 6'h20, ST 6'h21.
- Branch 6'b1100xx (6'h30–6'h33): `opcond` = opcode[1:0].
- HALT 6'h3F.
- Any other opcode is illegal.

States: IF, ID, EX, MEM, WB, HALT. Control lines not listed for a state are 0 in that state.
- IF: `readim`=`ldir`=`ldnpc`=1 → ID.
- ID: `ldA`=`ldB`=`ldimm`=1.
  - HALT opcode → HALT.
  - Illegal opcode → HALT, and set `illegal`.
  - Otherwise → EX.
- EX for ALU classes: `alusel1`=1, `alusel2` = (I-ALU), `aluen`=`ldaluout`=1 → WB.
- EX for LD/ST: `alusel1`=1, `alusel2`=1, `alufunc`=`ALU_ADD`, `aluen`=`ldaluout`=1 → MEM.
- EX for Branch: `opcond` driven, `branch`=1, `ldpc`=1, `retire`=1 → IF.
  - The datapath's condition logic decides whether the PC is taken or falls through.
- MEM for LD: `readdmem`=`ldlmd`=1 → WB.
- MEM for ST: `writedmem`=1, `ldpc`=1, `retire`=1 → IF.
- WB: `regwrite`=1, `ldpc`=1, `retire`=1.
  - `selwb`=1 for ALU classes, 0 for LD.
  - → IF.
- HALT: all controls 0, `halted`=1. Held until reset.

Cycles per instruction: ALU 4, LD 5, ST 4, Branch 3.

`alufunc` is 0 in every state other than EX.

## Timing
- Outputs are combinational from the state register and `irout[31:26]`/`irout[3:0]`. They are Moore-style with respect to the FSM.
- `irout` is stable from ID onward; it changes only at the IF→ID edge.
- While `reset` is high:
  - every output is forced to 0, asynchronously;
  - state = IF;
  - `illegal` = 0.
- First fetch is the first rising edge after `reset` deasserts.
- Reset asserted mid-instruction (including during MEM) aborts it. No write strobe survives into the reset cycle.
- `ldpc` is asserted exactly once per retired instruction, in its final cycle.
- `ldpc` is never asserted in IF, ID or HALT.

## Configuration
`KGP_MEM_WAIT_EN` is defined:
- The `dmem_ready` port exists.
- MEM holds while `dmem_ready`=0.
  - `readdmem`/`writedmem` stay asserted throughout.
  - `ldlmd` (LD), or `ldpc`+`retire` (ST), assert only in the cycle with `dmem_ready`=1.
  - The FSM advances on that cycle.

`KGP_MEM_WAIT_EN` is undefined:
- The `dmem_ready` port is absent.
- MEM is always a single cycle.

## Structure
- `kgp_ctrl_pkg` holds:
  - state enum;
  - opcode constants;
  - class enum (R_ALU, I_ALU, LD, ST, BR, HALT, ILLEGAL);
  - `ALU_ADD`=4'h0;
  - opcond codes.
- Sub-module `kgp_instr_decoder` is purely combinational. It maps `irout` to class and `alufunc`.
- The FSM and output decode stay in `kgp_control_unit`.

## Test plan
- **R-ALU.** Reset, then `irout`=0x00221802.
  - Sequence IF→ID→EX→WB.
  - EX: `alufunc`=2, `alusel1`=1, `alusel2`=0.
  - WB: `regwrite`=`selwb`=`ldpc`=1.
  - Next IF on cycle 5.
- **LD.** `irout`=0x80410010.
  - 5 cycles.
  - EX: `alufunc`=0, `alusel2`=1.
  - MEM: `readdmem`=`ldlmd`=1.
  - WB: `selwb`=0, `regwrite`=1.
  - Exactly one `retire`.
- **Branch.** `irout`=0xC4000008.
  - EX: `opcond`=01, `branch`=1, `ldpc`=1.
  - Returns to IF after 3 cycles.
  - `regwrite` never asserted.
- **HALT and illegal.**
  - `irout`=0xFC000000: `halted`=1 after ID, and `ldir` stays 0 for 10 further cycles.
  - Repeat with 0x28000000: also `illegal`=1.
  - Reset clears both flags.
- **Reset mid-store.** `irout`=0x84000004; assert reset during MEM.
  - `writedmem` drops to 0 in the same cycle, without waiting for a clock edge.
  - First cycle after release is IF with `readim`=1.
- **Memory wait (`KGP_MEM_WAIT_EN` defined).** LD with `dmem_ready` held 0 for 3 cycles.
  - `readdmem` stays high for 4 cycles.
  - `ldlmd` asserts only on the 4th cycle.
  - WB follows.

Source files
------------

// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multicycle control unit:
// FSM states, instruction classes, opcodes, ALU and branch-condition codes.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R_ALU   = 3'd0,
        CLS_I_ALU   = 3'd1,
        CLS_LD      = 3'd2,
        CLS_ST      = 3'd3,
        CLS_BR      = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_e;

    localparam logic [5:0] OP_R_ALU = 6'h00;
    localparam logic [5:0] OP_LD    = 6'h20;
    localparam logic [5:0] OP_ST    = 6'h21;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [3:0] ALU_ADD = 4'h0;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_ZERO   = 2'b01;
    localparam logic [1:0] COND_NZERO  = 2'b10;
    localparam logic [1:0] COND_NEG    = 2'b11;

    // Every control line driven towards the datapath, gathered so the whole
    // set can be cleared in one assignment.
    typedef struct packed {
        logic       readim;
        logic       ldir;
        logic       ldnpc;
        logic       lda;
        logic       ldb;
        logic       ldimm;
        logic [1:0] opcond;
        logic       alusel1;
        logic       alusel2;
        logic       aluen;
        logic       ldaluout;
        logic [3:0] alufunc;
        logic       writedmem;
        logic       readdmem;
        logic       ldlmd;
        logic       selwb;
        logic       regwrite;
        logic       branch;
        logic       ldpc;
        logic       retire;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    // ALU-class instructions share the EX and WB behaviour.
    function automatic logic is_alu_class(input instr_class_e cls);
        return (cls == CLS_R_ALU) || (cls == CLS_I_ALU);
    endfunction

endpackage

// File: rtl/kgp_control_unit_if.sv
// Bus between the KGP control unit and its datapath.
// KGP_MEM_WAIT_EN adds the dmem_ready handshake from data memory.
interface kgp_control_unit_if;
    logic [31:0] irout;
`ifdef KGP_MEM_WAIT_EN
    logic        dmem_ready;
`endif
    logic        readim;
    logic        ldir;
    logic        ldnpc;
    logic        ldA;
    logic        ldB;
    logic        ldimm;
    logic [1:0]  opcond;
    logic        alusel1;
    logic        alusel2;
    logic        aluen;
    logic        ldaluout;
    logic [3:0]  alufunc;
    logic        writedmem;
    logic        readdmem;
    logic        ldlmd;
    logic        selwb;
    logic        regwrite;
    logic        branch;
    logic        ldpc;
    logic        retire;
    logic        halted;
    logic        illegal;

    modport master (
        input  irout,
`ifdef KGP_MEM_WAIT_EN
        input  dmem_ready,
`endif
        output readim, ldir, ldnpc, ldA, ldB, ldimm, opcond,
        output alusel1, alusel2, aluen, ldaluout, alufunc,
        output writedmem, readdmem, ldlmd, selwb, regwrite,
        output branch, ldpc, retire, halted, illegal
    );

    modport slave (
        output irout,
`ifdef KGP_MEM_WAIT_EN
        output dmem_ready,
`endif
        input  readim, ldir, ldnpc, ldA, ldB, ldimm, opcond,
        input  alusel1, alusel2, aluen, ldaluout, alufunc,
        input  writedmem, readdmem, ldlmd, selwb, regwrite,
        input  branch, ldpc, retire, halted, illegal
    );
endinterface

// File: rtl/kgp_instr_decoder.sv
// Combinational instruction classifier: opcode/funct -> class and ALU function.
module kgp_instr_decoder
    import kgp_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [3:0]   funct,
    output instr_class_e cls,
    output logic [3:0]   alufunc
);

    // Classify the opcode and pick the ALU operation the class implies.
    always_comb begin
        cls     = CLS_ILLEGAL;
        alufunc = ALU_ADD;
        casez (opcode)
            6'b00_0000: begin
                cls     = CLS_R_ALU;
                alufunc = funct;
            end
            6'b01_????: begin
                cls     = CLS_I_ALU;
                alufunc = opcode[3:0];
            end
            6'b10_0000: cls = CLS_LD;
            6'b10_0001: cls = CLS_ST;
            6'b11_00??: cls = CLS_BR;
            6'b11_1111: cls = CLS_HALT;
            default: begin
                cls     = CLS_ILLEGAL;
                alufunc = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/kgp_control_unit.sv
// KGP-RISC multicycle control FSM (IF/ID/EX/MEM/WB/HALT).
// Optional feature macro: KGP_MEM_WAIT_EN -- MEM holds until dmem_ready.
// All outputs are decoded from the state register and are forced low while
// reset is high, independent of the clock.
module kgp_control_unit
    import kgp_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    kgp_control_unit_if.master bus
);

    state_e       state;
    state_e       next_state;
    instr_class_e cls;
    logic [3:0]   dec_alufunc;
    logic         illegal_flag;
    logic         set_illegal;
    logic         mem_go;
    ctrl_t        ctl;
    ctrl_t        ctl_out;

    kgp_instr_decoder u_decoder (
        .opcode  (bus.irout[31:26]),
        .funct   (bus.irout[3:0]),
        .cls     (cls),
        .alufunc (dec_alufunc)
    );

`ifdef KGP_MEM_WAIT_EN
    assign mem_go = bus.dmem_ready;
`else
    assign mem_go = 1'b1;
`endif

    // State register; reset restarts at instruction fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IF;
        end else begin
            state <= next_state;
        end
    end

    // Sticky record that HALT was reached through an undefined opcode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_flag <= 1'b0;
        end else if (set_illegal) begin
            illegal_flag <= 1'b1;
        end else begin
            illegal_flag <= illegal_flag;
        end
    end

    // Next-state selection and per-state control decode.
    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        ctl         = '0;
        case (state)
            ST_IF: begin
                ctl.readim = 1'b1;
                ctl.ldir   = 1'b1;
                ctl.ldnpc  = 1'b1;
                next_state = ST_ID;
            end
            ST_ID: begin
                ctl.lda   = 1'b1;
                ctl.ldb   = 1'b1;
                ctl.ldimm = 1'b1;
                if (cls == CLS_HALT) begin
                    next_state = ST_HALT;
                end else if (cls == CLS_ILLEGAL) begin
                    next_state  = ST_HALT;
                    set_illegal = 1'b1;
                end else begin
                    next_state = ST_EX;
                end
            end
            ST_EX: begin
                case (cls)
                    CLS_R_ALU, CLS_I_ALU: begin
                        ctl.alusel1  = 1'b1;
                        ctl.alusel2  = (cls == CLS_I_ALU);
                        ctl.aluen    = 1'b1;
                        ctl.ldaluout = 1'b1;
                        ctl.alufunc  = dec_alufunc;
                        next_state   = ST_WB;
                    end
                    CLS_LD, CLS_ST: begin
                        ctl.alusel1  = 1'b1;
                        ctl.alusel2  = 1'b1;
                        ctl.aluen    = 1'b1;
                        ctl.ldaluout = 1'b1;
                        ctl.alufunc  = ALU_ADD;
                        next_state   = ST_MEM;
                    end
                    CLS_BR: begin
                        // Taken/not-taken is resolved by the datapath's
                        // condition logic; the PC is always reloaded here.
                        ctl.opcond = bus.irout[27:26];
                        ctl.branch = 1'b1;
                        ctl.ldpc   = 1'b1;
                        ctl.retire = 1'b1;
                        next_state = ST_IF;
                    end
                    default: next_state = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (cls == CLS_LD) begin
                    ctl.readdmem = 1'b1;
                    ctl.ldlmd    = mem_go;
                    next_state   = mem_go ? ST_WB : ST_MEM;
                end else if (cls == CLS_ST) begin
                    ctl.writedmem = 1'b1;
                    ctl.ldpc      = mem_go;
                    ctl.retire    = mem_go;
                    next_state    = mem_go ? ST_IF : ST_MEM;
                end else begin
                    next_state = ST_HALT;
                end
            end
            ST_WB: begin
                ctl.regwrite = 1'b1;
                ctl.ldpc     = 1'b1;
                ctl.retire   = 1'b1;
                ctl.selwb    = is_alu_class(cls);
                next_state   = ST_IF;
            end
            ST_HALT: begin
                ctl.halted = 1'b1;
                next_state = ST_HALT;
            end
            default: next_state = ST_IF;
        endcase
        ctl.illegal = illegal_flag;
    end

    // Reset gates every output low immediately, so no strobe outlives it.
    always_comb begin
        if (reset) begin
            ctl_out = '0;
        end else begin
            ctl_out = ctl;
        end
    end

    assign bus.readim    = ctl_out.readim;
    assign bus.ldir      = ctl_out.ldir;
    assign bus.ldnpc     = ctl_out.ldnpc;
    assign bus.ldA       = ctl_out.lda;
    assign bus.ldB       = ctl_out.ldb;
    assign bus.ldimm     = ctl_out.ldimm;
    assign bus.opcond    = ctl_out.opcond;
    assign bus.alusel1   = ctl_out.alusel1;
    assign bus.alusel2   = ctl_out.alusel2;
    assign bus.aluen     = ctl_out.aluen;
    assign bus.ldaluout  = ctl_out.ldaluout;
    assign bus.alufunc   = ctl_out.alufunc;
    assign bus.writedmem = ctl_out.writedmem;
    assign bus.readdmem  = ctl_out.readdmem;
    assign bus.ldlmd     = ctl_out.ldlmd;
    assign bus.selwb     = ctl_out.selwb;
    assign bus.regwrite  = ctl_out.regwrite;
    assign bus.branch    = ctl_out.branch;
    assign bus.ldpc      = ctl_out.ldpc;
    assign bus.retire    = ctl_out.retire;
    assign bus.halted    = ctl_out.halted;
    assign bus.illegal   = ctl_out.illegal;

endmodule
